// File: rtl/disp_share_arbiter.sv
// Round-robin arbiter that lends a shared 6-digit display to one of three requesters,
// with a minimum hold time and a forced rotation after MAX_HOLD cycles under contention.
module disp_share_arbiter #(
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [23:0] HEX_0,
    input  logic [23:0] HEX_1,
    input  logic [23:0] HEX_2,
    input  logic [7:0]  DPM_0,
    input  logic [7:0]  DPM_1,
    input  logic [7:0]  DPM_2,
    output logic [2:0]  GNT,
    output logic [23:0] HEX_OUT,
    output logic [7:0]  DP_OUT,
    output logic        BLANK
);

    localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0] MinCnt = CntW'(MIN_HOLD - 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StHold, StOwn} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [23:0]     hex_q, hex_d;
    logic [7:0]      dp_q, dp_d;
    logic            blank_q, blank_d;

    logic            cand_valid;
    logic [1:0]      cand_idx, scan_idx;
    logic            owner_req, others_req;
    logic            grant_new, track, load;
    logic [1:0]      src_idx;

    // Later iterations win, so scanning ptr+3 down to ptr+1 gives ptr+1 top priority.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 3; i >= 1; i--) begin
            scan_idx = 2'((int'(ptr_q) + i) % 3);
            if (REQ[scan_idx]) begin
                cand_valid = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    assign owner_req  = REQ[ptr_q];
    assign others_req = |(REQ & ~(3'b001 << ptr_q));
    assign cnt_inc    = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= 2'd2;
            gnt_q   <= 3'b000;
            hex_q   <= 24'h000000;
            dp_q    <= 8'h00;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_new = 1'b0;
        track     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand_valid) grant_new = 1'b1;
            end
            StHold: begin
                cnt_d = cnt_inc;
                track = owner_req;
                if (cnt_d == MinCnt) state_d = StOwn;
            end
            StOwn: begin
                if (!owner_req) begin
                    if (cand_valid) grant_new = 1'b1;
                    else            state_d   = StIdle;
                end else if ((cnt_q == MaxCnt) && others_req) begin
                    grant_new = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    track = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant_new) begin
            ptr_d   = cand_idx;
            cnt_d   = '0;
            state_d = (MIN_HOLD == 1) ? StOwn : StHold;
        end
    end

    always_comb begin
        gnt_d   = gnt_q;
        blank_d = blank_q;
        hex_d   = hex_q;
        dp_d    = dp_q;
        load    = grant_new | track;
        src_idx = grant_new ? cand_idx : ptr_q;
        if (load) begin
            case (src_idx)
                2'd0: begin
                    hex_d = HEX_0;
                    dp_d  = DPM_0;
                end
                2'd1: begin
                    hex_d = HEX_1;
                    dp_d  = DPM_1;
                end
                default: begin
                    hex_d = HEX_2;
                    dp_d  = DPM_2;
                end
            endcase
        end
        if (state_d == StIdle) begin
            gnt_d   = 3'b000;
            blank_d = 1'b1;
        end else begin
            gnt_d   = 3'b001 << ptr_d;
            blank_d = 1'b0;
        end
    end

    assign GNT     = gnt_q;
    assign HEX_OUT = hex_q;
    assign DP_OUT  = dp_q;
    assign BLANK   = blank_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Bench for disp_share_arbiter: directed scenarios plus randomized traffic checked against
// an integer-age ownership model.
module tb_disp_share_arbiter;

    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  REQ;
    logic [23:0] HEX_0, HEX_1, HEX_2;
    logic [7:0]  DPM_0, DPM_1, DPM_2;
    logic [2:0]  GNT;
    logic [23:0] HEX_OUT;
    logic [7:0]  DP_OUT;
    logic        BLANK;
    logic [35:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner (-1 = none), last granted, cycles held since grant, latched data.
    int          m_owner = -1;
    int          m_last  = 2;
    int          m_age   = 0;
    logic [23:0] m_hex   = 24'h0;
    logic [7:0]  m_dp    = 8'h0;

    disp_share_arbiter #(
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .HEX_0   (HEX_0),
        .HEX_1   (HEX_1),
        .HEX_2   (HEX_2),
        .DPM_0   (DPM_0),
        .DPM_1   (DPM_1),
        .DPM_2   (DPM_2),
        .GNT     (GNT),
        .HEX_OUT (HEX_OUT),
        .DP_OUT  (DP_OUT),
        .BLANK   (BLANK)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {GNT, BLANK, HEX_OUT, DP_OUT};

    function automatic int pick(input logic [2:0] r, input int last);
        int k;
        for (int i = 1; i <= 3; i++) begin
            k = (last + i) % 3;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [23:0] hex_in(input int k);
        return (k == 0) ? HEX_0 : (k == 1) ? HEX_1 : HEX_2;
    endfunction

    function automatic logic [7:0] dpm_in(input int k);
        return (k == 0) ? DPM_0 : (k == 1) ? DPM_1 : DPM_2;
    endfunction

    function automatic void m_grant(input int k);
        m_owner = k;
        m_last  = k;
        m_age   = 0;
        m_hex   = hex_in(k);
        m_dp    = dpm_in(k);
    endfunction

    function automatic void model_edge();
        int nxt;
        nxt = pick(REQ, m_last);
        if (RST) begin
            m_owner = -1;
            m_last  = 2;
            m_age   = 0;
            m_hex   = 24'h0;
            m_dp    = 8'h0;
        end else if (m_owner < 0) begin
            if (nxt >= 0) m_grant(nxt);
        end else if (m_age < MIN_HOLD - 1) begin
            m_age++;
            if (REQ[m_owner]) begin
                m_hex = hex_in(m_owner);
                m_dp  = dpm_in(m_owner);
            end
        end else if (!REQ[m_owner]) begin
            if (nxt >= 0) m_grant(nxt);
            else          m_owner = -1;
        end else if (m_age >= MAX_HOLD - 1 && nxt != m_owner) begin
            m_grant(nxt);
        end else begin
            m_age++;
            m_hex = hex_in(m_owner);
            m_dp  = dpm_in(m_owner);
        end
    endfunction

    function automatic logic [35:0] exp_vec();
        logic [2:0] g;
        g = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        return {g, (m_owner < 0), m_hex, m_dp};
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = 3'b000;
        cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        REQ   = 3'b111;
        HEX_0 = 24'h111111;
        HEX_1 = 24'h222222;
        HEX_2 = 24'h333333;
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== {3'b000, 1'b1, 24'h000000, 8'h00}) begin
                n_bad++;
                $display("FAIL reset c%0d: got %h want %h", c, dut_vec,
                         {3'b000, 1'b1, 24'h000000, 8'h00});
            end
        end
        RST = 1'b0;
        REQ = 3'b000;
    endtask

    task automatic test_single();
        do_reset();
        REQ   = 3'b001;
        HEX_0 = 24'h123456;
        DPM_0 = 8'h04;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b001, 1'b0, 24'h123456, 8'h04}) begin
            n_bad++;
            $display("FAIL single_grant: got %h want %h", dut_vec,
                     {3'b001, 1'b0, 24'h123456, 8'h04});
        end
        HEX_0 = 24'h654321;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b001, 1'b0, 24'h654321, 8'h04} || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_track: got %h want %h", dut_vec,
                     {3'b001, 1'b0, 24'h654321, 8'h04});
        end
        REQ = 3'b000;
    endtask

    task automatic test_min_hold();
        logic [2:0] want;
        do_reset();
        REQ   = 3'b001;
        HEX_0 = 24'hABCDEF;
        cycle();
        REQ   = 3'b000;
        HEX_0 = 24'h111111;
        for (int c = 1; c <= 5; c++) begin
            want = (c <= 4) ? 3'b001 : 3'b000;
            n_cmp++;
            if (GNT !== want || BLANK !== (c == 5) || HEX_OUT !== 24'hABCDEF) begin
                n_bad++;
                $display("FAIL min_hold t+%0d: got gnt=%b blank=%b hex=%h want gnt=%b hex=abcdef",
                         c, GNT, BLANK, HEX_OUT, want);
            end
            if (c < 5) cycle();
        end
    endtask

    task automatic test_rotation();
        logic [2:0] want;
        do_reset();
        REQ = 3'b011;
        for (int c = 1; c <= 48; c++) begin
            cycle();
            want = (((c - 1) / 16) % 2 == 0) ? 3'b001 : 3'b010;
            n_cmp++;
            if (GNT !== want || BLANK !== 1'b0 || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL rotation c%0d: got gnt=%b blank=%b want gnt=%b", c, GNT, BLANK,
                         want);
            end
        end
        REQ = 3'b000;
    endtask

    task automatic test_fairness();
        logic [2:0] want;
        do_reset();
        REQ = 3'b111;
        for (int c = 1; c <= 52; c++) begin
            cycle();
            want = 3'(1 << (((c - 1) / 16) % 3));
            n_cmp++;
            if (GNT !== want || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL fairness c%0d: got gnt=%b want %b", c, GNT, want);
            end
        end
        do_reset();
        REQ = 3'b111;
        for (int c = 1; c <= 22; c++) cycle();
        n_cmp++;
        if (GNT !== 3'b010) begin
            n_bad++;
            $display("FAIL fair_owner1: got gnt=%b want 010", GNT);
        end
        REQ = 3'b101;
        cycle();
        n_cmp++;
        if (GNT !== 3'b100 || BLANK !== 1'b0) begin
            n_bad++;
            $display("FAIL fair_drop: got gnt=%b blank=%b want gnt=100 blank=0", GNT, BLANK);
        end
        REQ = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ   = 3'b010;
        HEX_1 = 24'h0F0F0F;
        DPM_1 = 8'h5A;
        cycle();
        cycle();
        n_cmp++;
        if (GNT !== 3'b010) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got gnt=%b want 010", GNT);
        end
        RST = 1'b1;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b000, 1'b1, 24'h000000, 8'h00}) begin
            n_bad++;
            $display("FAIL rst_mid_clear: got %h want %h", dut_vec,
                     {3'b000, 1'b1, 24'h000000, 8'h00});
        end
        RST = 1'b0;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b010, 1'b0, 24'h0F0F0F, 8'h5A}) begin
            n_bad++;
            $display("FAIL rst_mid_regrant: got %h want %h", dut_vec,
                     {3'b010, 1'b0, 24'h0F0F0F, 8'h5A});
        end
        REQ = 3'b000;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) REQ = 3'($urandom_range(0, 7));
            RST   = ($urandom_range(0, 199) == 0);
            HEX_0 = 24'($urandom);
            HEX_1 = 24'($urandom);
            HEX_2 = 24'($urandom);
            DPM_0 = 8'($urandom);
            DPM_1 = 8'($urandom);
            DPM_2 = 8'($urandom);
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec() || !$onehot0(GNT) || BLANK !== (GNT == 3'b000)) begin
                n_bad++;
                $display("FAIL random c%0d req=%b: got %h want %h", c, REQ, dut_vec, exp_vec());
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        REQ   = 3'b000;
        HEX_0 = 24'h0;
        HEX_1 = 24'h0;
        HEX_2 = 24'h0;
        DPM_0 = 8'h0;
        DPM_1 = 8'h0;
        DPM_2 = 8'h0;
        test_reset();
        test_single();
        test_min_hold();
        test_rotation();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_share_arbiter.md
DISP_SHARE_ARBITER -- requirements
Module: disp_share_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 4: minimum cycles a grant is held once issued (>=1).
REQ-002 Parameter MAX_HOLD, default 16: cycles after which a grant is forcibly rotated if another requester waits (MAX_HOLD >= MIN_HOLD).
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 REQ  in  3  per-requester display request, bit k = requester k.
REQ-006 HEX_0, HEX_1, HEX_2  in  24 each  six 4-bit digit codes from requester k.
REQ-007 DPM_0, DPM_1, DPM_2  in  8 each  decimal-point mask from requester k.
REQ-008 GNT  out  3  registered one-hot grant; all-zero when nobody owns the display.
REQ-009 HEX_OUT  out  24  registered digit codes to the display driver.
REQ-010 DP_OUT  out  8  registered decimal-point mask to the display driver.
REQ-011 BLANK  out  1  registered; 1 = no owner, driver shall blank all digits.

Function
REQ-012 States: IDLE (no owner), HOLD (owner, cnt < MIN_HOLD-1), OWN (owner, minimum time served).
REQ-013 cnt: cycle counter, 0 in first granted cycle, +1 per cycle, saturates at MAX_HOLD-1; width = clog2(MAX_HOLD).
REQ-014 ptr: 2-bit index of last granted requester; round-robin search order is ptr+1, ptr+2, ptr (mod 3).
REQ-015 Grant issue: on the edge where a new owner k is selected, GNT <= one-hot(k), ptr <= k, cnt <= 0, HEX_OUT <= HEX_k, DP_OUT <= DPM_k, BLANK <= 0, state <= HOLD (or OWN if MIN_HOLD==1).
REQ-016 Latency: REQ seen in IDLE at cycle t -> GNT, HEX_OUT, DP_OUT valid and BLANK=0 at cycle t+1.
REQ-017 IDLE: if REQ != 0, grant first set bit in round-robin order; else hold outputs, GNT=0, BLANK=1.
REQ-018 Data tracking: while owned and REQ[owner]=1, HEX_OUT/DP_OUT reload from owner's inputs every cycle; when REQ[owner]=0, they are frozen.
REQ-019 HOLD: owner's REQ ignored for release; at cnt==MIN_HOLD-1 transition to OWN next cycle.
REQ-020 OWN, REQ[owner]=0: if any other REQ set, grant next in round-robin order on the same edge (no blank gap); else IDLE, GNT<=0, BLANK<=1, HEX_OUT/DP_OUT unchanged.
REQ-021 OWN, REQ[owner]=1, cnt==MAX_HOLD-1 and another REQ set: rotate to next requester in round-robin order.
REQ-022 OWN, REQ[owner]=1, no other REQ: keep grant indefinitely, cnt saturated.
REQ-023 Release-and-request-again by owner alone in OWN: goes IDLE one cycle only if REQ[owner]=0 that cycle; re-grant follows REQ-017.
REQ-024 GNT shall be one-hot or zero at all times; BLANK == (GNT == 0) at all times.

Reset
REQ-025 RST=1 at an edge: state IDLE, GNT=000, HEX_OUT=0x000000, DP_OUT=0x00, BLANK=1, cnt=0, ptr=2 (requester 0 first).
REQ-026 RST overrides all other inputs, including mid-HOLD/OWN; first grant possible at the edge after RST deasserts.

Verification (MIN_HOLD=4, MAX_HOLD=16)
REQ-027 Reset: assert RST 2 cycles with REQ=111 -> GNT=000, BLANK=1, HEX_OUT=0, DP_OUT=0 throughout.
REQ-028 Single: REQ=001, HEX_0=0x123456, DPM_0=0x04 at cycle t -> cycle t+1 GNT=001, HEX_OUT=0x123456, DP_OUT=0x04, BLANK=0; HEX_0 changed to 0x654321 -> HEX_OUT follows one cycle later.
REQ-029 Min hold: REQ0 one-cycle pulse, HEX_0=0xABCDEF -> GNT=001 cycles t+1..t+4, GNT=000/BLANK=1 at t+5, HEX_OUT stays 0xABCDEF.
REQ-030 Rotation: REQ=011 continuous from reset -> GNT=001 for 16 cycles, then 010 for 16, then 001, no cycle with GNT=000.
REQ-031 Fairness: REQ=111 continuous from reset -> grant order 0,1,2,0 each 16 cycles; owner 1 drops REQ after 6 cycles -> GNT=100 on next edge.
REQ-032 Reset mid-operation: RST for 1 cycle while GNT=010 in HOLD -> next cycle GNT=000, BLANK=1, HEX_OUT=0; with REQ=010 still high, GNT=010 returns the cycle after RST falls.
